// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the fetch program-counter controller:
//   - pc_state_e     : controller state encoding (BOOT/RUN/HALT)
//   - DEF_RESET_ADDR : default first fetch address after reset
//   - DEF_TRAP_ADDR  : default trap / misaligned-redirect vector
//   - is_misaligned  : checks that the low align_bits of an address are zero
// -----------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_ADDR  = 32'h0000_0100;

  // Address is passed zero-extended to 64 bits so one function serves any
  // XLEN up to 64; align_bits of 0 means every address is aligned.
  function automatic logic is_misaligned(input logic [63:0] addr,
                                         input int unsigned align_bits);
    logic bad_v;
    bad_v = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < align_bits) begin
        bad_v = bad_v | addr[i];
      end else begin
        bad_v = bad_v;
      end
    end
    return bad_v;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
// Generates the fetch PC and presents it to instruction memory on a
// valid/ready handshake. Handles sequential increment, backend stall,
// redirect, trap vectoring, misaligned-redirect detection and a halt state.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_stall             backend stall: hold PC, do not accept
//   i_ready             imem ready for a request
//   i_redirect_valid    redirect request, target on i_redirect_pc
//   i_trap              take the trap vector
//   i_halt              enter HALT after the current cycle (RUN only)
//   o_pc                current fetch address
//   o_valid             fetch request valid (registered, RUN only)
//   o_accept            o_valid & i_ready & ~i_stall (combinational)
//   o_misaligned        one-cycle pulse after a misaligned redirect
//   o_bad_addr          last misaligned redirect target
//   o_fetch_cnt         accepted-fetch counter (wraps)
//   o_state             BOOT=0, RUN=1, HALT=2
// -----------------------------------------------------------------------------
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(DEF_RESET_ADDR),
  parameter logic [XLEN-1:0] TRAP_ADDR  = XLEN'(DEF_TRAP_ADDR),
  parameter int unsigned     INC        = 4,
  parameter int unsigned     ALIGN_BITS = 2,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_ready,
  input  logic             i_redirect_valid,
  input  logic [XLEN-1:0]  i_redirect_pc,
  input  logic             i_trap,
  input  logic             i_halt,
  output logic [XLEN-1:0]  o_pc,
  output logic             o_valid,
  output logic             o_accept,
  output logic             o_misaligned,
  output logic [XLEN-1:0]  o_bad_addr,
  output logic [CNT_W-1:0] o_fetch_cnt,
  output logic [1:0]       o_state
);

  localparam logic [XLEN-1:0]  INC_V = XLEN'(INC);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  pc_state_e        state_r;
  logic [XLEN-1:0]  pc_r;
  logic             valid_r;
  logic             misaligned_r;
  logic [XLEN-1:0]  bad_addr_r;
  logic [CNT_W-1:0] fetch_cnt_r;

  logic             accept_s;
  logic             redir_bad_s;
  logic             mis_evt_s;
  logic [XLEN-1:0]  pc_next_s;
  pc_state_e        state_next_s;

  assign accept_s    = valid_r & i_ready & ~i_stall;
  assign redir_bad_s = i_redirect_valid & is_misaligned(64'(i_redirect_pc), ALIGN_BITS);

  // Next-PC / next-state selection: trap > aligned redirect > misaligned
  // redirect > accept > hold. Trap/redirect ignore stall and ready.
  always_comb begin
    pc_next_s    = pc_r;
    state_next_s = state_r;
    mis_evt_s    = 1'b0;
    case (state_r)
      ST_BOOT: begin
        // Control inputs are ignored for the single BOOT cycle.
        pc_next_s    = pc_r;
        state_next_s = ST_RUN;
      end
      ST_RUN, ST_HALT: begin
        if (i_trap) begin
          pc_next_s    = TRAP_ADDR;
          state_next_s = ST_RUN;
        end else if (i_redirect_valid && !redir_bad_s) begin
          pc_next_s    = i_redirect_pc;
          state_next_s = ST_RUN;
        end else if (redir_bad_s) begin
          pc_next_s    = TRAP_ADDR;
          state_next_s = ST_RUN;
          mis_evt_s    = 1'b1;
        end else if (state_r == ST_HALT) begin
          pc_next_s    = pc_r;
          state_next_s = ST_HALT;
        end else begin
          // RUN: an accept in the halting cycle still advances the PC.
          if (accept_s) begin
            pc_next_s = pc_r + INC_V;
          end else begin
            pc_next_s = pc_r;
          end
          if (i_halt) begin
            state_next_s = ST_HALT;
          end else begin
            state_next_s = ST_RUN;
          end
        end
      end
      default: begin
        pc_next_s    = RESET_ADDR;
        state_next_s = ST_BOOT;
      end
    endcase
  end

  // State, PC and request-valid registers; valid follows the next state so
  // it is high exactly while in RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_BOOT;
      pc_r    <= RESET_ADDR;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      valid_r <= (state_next_s == ST_RUN);
    end
  end

  // Misaligned-redirect pulse and sticky bad-address capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      misaligned_r <= 1'b0;
      bad_addr_r   <= '0;
    end else begin
      misaligned_r <= mis_evt_s;
      if (mis_evt_s) begin
        bad_addr_r <= i_redirect_pc;
      end else begin
        bad_addr_r <= bad_addr_r;
      end
    end
  end

  // Accepted-fetch counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_cnt_r <= '0;
    end else if (accept_s) begin
      fetch_cnt_r <= fetch_cnt_r + ONE_C;
    end else begin
      fetch_cnt_r <= fetch_cnt_r;
    end
  end

  assign o_pc         = pc_r;
  assign o_valid      = valid_r;
  assign o_accept     = accept_s;
  assign o_misaligned = misaligned_r;
  assign o_bad_addr   = bad_addr_r;
  assign o_fetch_cnt  = fetch_cnt_r;
  assign o_state      = state_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Directed-vector bench for pc_fetch_ctrl with default parameters.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ready;
  logic        redir_v;
  logic [31:0] redir_pc;
  logic        trap;
  logic        halt;
  logic [31:0] pc;
  logic        valid;
  logic        accept;
  logic        misaligned;
  logic [31:0] bad_addr;
  logic [15:0] fetch_cnt;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  pc_fetch_ctrl dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stall          (stall),
    .i_ready          (ready),
    .i_redirect_valid (redir_v),
    .i_redirect_pc    (redir_pc),
    .i_trap           (trap),
    .i_halt           (halt),
    .o_pc             (pc),
    .o_valid          (valid),
    .o_accept         (accept),
    .o_misaligned     (misaligned),
    .o_bad_addr       (bad_addr),
    .o_fetch_cnt      (fetch_cnt),
    .o_state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_run(input string tag, input logic [31:0] e_pc,
                         input logic [1:0] e_st, input logic e_v, input logic [15:0] e_cnt);
    check({tag, ".pc"},    64'(pc),        64'(e_pc));
    check({tag, ".state"}, 64'(state),     64'(e_st));
    check({tag, ".valid"}, 64'(valid),     64'(e_v));
    check({tag, ".cnt"},   64'(fetch_cnt), 64'(e_cnt));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ready = 1'b1; redir_v = 1'b0;
    redir_pc = 32'h0; trap = 1'b0; halt = 1'b0;
    step(); step();
    chk_run("reset", 32'h0, 2'd0, 1'b0, 16'd0);
    check("reset.mis", 64'(misaligned), 64'd0);
    check("reset.bad", 64'(bad_addr),   64'd0);

    // BOOT cycle: trap is ignored, PC stays at the reset address.
    rst = 1'b0; trap = 1'b1;
    #1;
    chk_run("boot", 32'h0, 2'd0, 1'b0, 16'd0);
    check("boot.accept", 64'(accept), 64'd0);
    step(); trap = 1'b0;
    chk_run("run0", 32'h0, 2'd1, 1'b1, 16'd0);
    check("run0.accept", 64'(accept), 64'd1);
    step(); chk_run("seq4",  32'h4,  2'd1, 1'b1, 16'd1);
    step(); chk_run("seq8",  32'h8,  2'd1, 1'b1, 16'd2);
    step(); chk_run("seq12", 32'hC,  2'd1, 1'b1, 16'd3);
    step(); chk_run("seq16", 32'h10, 2'd1, 1'b1, 16'd4);

    // Stall holds PC and count, valid stays high.
    stall = 1'b1; #1;
    check("stall.accept", 64'(accept), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(); chk_run("stall", 32'h10, 2'd1, 1'b1, 16'd4);
    end
    stall = 1'b0;
    step(); chk_run("unstall", 32'h14, 2'd1, 1'b1, 16'd5);

    // Redirect with an accept in the same cycle: count advances, PC jumps.
    redir_v = 1'b1; redir_pc = 32'h20;
    step(); chk_run("redir20", 32'h20, 2'd1, 1'b1, 16'd6);
    stall = 1'b1; redir_pc = 32'h80;
    step(); chk_run("redir_stall", 32'h80, 2'd1, 1'b1, 16'd6);
    trap = 1'b1;
    step(); chk_run("trap_over_redir", 32'h100, 2'd1, 1'b1, 16'd6);
    trap = 1'b0;

    // Misaligned redirect -> trap vector, one-cycle pulse, sticky bad address.
    redir_pc = 32'h42;
    step(); chk_run("mis", 32'h100, 2'd1, 1'b1, 16'd6);
    check("mis.pulse", 64'(misaligned), 64'd1);
    check("mis.bad",   64'(bad_addr),   64'h42);
    redir_v = 1'b0;
    step();
    check("mis.pulse_end", 64'(misaligned), 64'd0);
    check("mis.bad_hold",  64'(bad_addr),   64'h42);
    check("mis.pc_hold",   64'(pc),         64'h100);

    // Halt with an accept in the same cycle.
    redir_v = 1'b1; redir_pc = 32'h30;
    step(); redir_v = 1'b0; stall = 1'b0; halt = 1'b1;
    chk_run("at30", 32'h30, 2'd1, 1'b1, 16'd6);
    step(); chk_run("halt", 32'h34, 2'd2, 1'b0, 16'd7);
    #1; check("halt.accept", 64'(accept), 64'd0);
    // Stays halted; i_halt in HALT is ignored.
    for (int i = 0; i < 5; i++) begin
      halt = (i < 2);
      step(); chk_run("halt_hold", 32'h34, 2'd2, 1'b0, 16'd7);
    end
    redir_v = 1'b1; redir_pc = 32'h200;
    step(); chk_run("halt_exit", 32'h200, 2'd1, 1'b1, 16'd7);

    // Wrap at the top of the address space.
    redir_pc = 32'hFFFF_FFFC;
    step(); chk_run("top", 32'hFFFF_FFFC, 2'd1, 1'b1, 16'd8);
    redir_v = 1'b0;
    step(); chk_run("wrap", 32'h0, 2'd1, 1'b1, 16'd9);

    // Redirect wins over halt in the same cycle.
    stall = 1'b1; halt = 1'b1; redir_v = 1'b1; redir_pc = 32'h50;
    step(); chk_run("redir_over_halt", 32'h50, 2'd1, 1'b1, 16'd9);
    halt = 1'b0; redir_v = 1'b0;

    // Reset in the middle of a stall.
    rst = 1'b1;
    step(); chk_run("mid_rst", 32'h0, 2'd0, 1'b0, 16'd0);
    check("mid_rst.bad", 64'(bad_addr), 64'd0);
    rst = 1'b0; stall = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Parametrised successor to the single-register PC. Generates the fetch PC for the front end and presents it on a valid/ready handshake to instruction memory. Handles sequential increment, backend stall, redirect (branch/jump), trap vectoring, a misaligned-target check, and a halt state. Sits between the fetch stage and the imem port, replacing the free-running PC register.

Parameters:
XLEN, 32, PC and address width
RESET_ADDR, 32'h00000000, first fetch address after reset
TRAP_ADDR, 32'h00000100, vector taken on i_trap or on a misaligned redirect
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, low PC bits that must be zero
CNT_W, 16, width of the accepted-fetch counter

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_stall  in  1  backend stall: hold PC, do not accept
i_ready  in  1  imem ready for a request
i_redirect_valid  in  1  redirect request (branch/jump resolved)
i_redirect_pc  in  XLEN  redirect target
i_trap  in  1  take trap vector
i_halt  in  1  enter HALT after the current cycle
o_pc  out  XLEN  current fetch address
o_valid  out  1  fetch request valid
o_accept  out  1  o_valid & i_ready & ~i_stall (combinational)
o_misaligned  out  1  one-cycle pulse: redirect target was misaligned
o_bad_addr  out  XLEN  misaligned target captured at the pulse
o_fetch_cnt  out  CNT_W  count of accepted fetches
o_state  out  2  BOOT=0, RUN=1, HALT=2

Behaviour:
- Reset (i_rst=1 at posedge), overrides everything:
  - o_pc=RESET_ADDR, state=BOOT, o_valid=0
  - o_misaligned=0, o_bad_addr=0, o_fetch_cnt=0
- BOOT: lasts exactly one cycle after reset release, then RUN. o_pc stays RESET_ADDR, so the first request is RESET_ADDR.
- RUN: o_valid=1. o_valid does not depend on i_ready or i_stall. o_pc stays stable while not accepted.
- HALT: o_valid=0 and o_pc holds.
  - Leaves HALT only on i_trap or i_redirect_valid, which load the new PC and return to RUN.
  - i_halt while in HALT is ignored.
- Next-PC priority, evaluated in RUN and HALT, highest first:
  1. i_trap -> TRAP_ADDR
  2. i_redirect_valid with aligned target -> i_redirect_pc
  3. i_redirect_valid with misaligned target (i_redirect_pc[ALIGN_BITS-1:0]!=0) -> TRAP_ADDR, o_misaligned=1 next cycle, o_bad_addr=i_redirect_pc
  4. accept -> o_pc+INC, modulo 2^XLEN (wraps, no flag)
  5. otherwise hold
- Trap and redirect apply next cycle regardless of i_stall or i_ready. They discard any unaccepted request at the old PC.
- i_halt (RUN only, no trap/redirect in the same cycle) -> HALT next cycle. An accept in that same cycle still advances the PC and counts. Trap/redirect win over i_halt.
- During BOOT, trap, redirect and halt inputs are ignored.
- o_misaligned is a one-cycle pulse. o_bad_addr holds until the next misaligned event.
- o_fetch_cnt increments by 1 on each accept and wraps at 2^CNT_W.
- Latency: input to o_pc/o_state change is one cycle; o_accept is combinational.

Decomposition:
- Shared package pc_pkg:
  - state enum (BOOT/RUN/HALT)
  - default RESET_ADDR / TRAP_ADDR constants
  - misaligned-check function parameterised by ALIGN_BITS
- Sub-module: none required. Next-PC mux and counter stay inline; the state register is kept in the same always block as o_pc.

Test Plan:
- Reset then i_ready=1, no stall -> cycle1 BOOT, o_valid=0, o_pc=0; then o_pc 0,4,8,12 on successive cycles, o_fetch_cnt=3 after three accepts.
- RUN at o_pc=0x10, i_stall=1 for 3 cycles -> o_pc stays 0x10, o_valid=1, o_accept=0, count unchanged; release -> 0x14.
- At o_pc=0x20, i_stall=1 plus redirect to 0x80 -> next o_pc=0x80. Same cycle i_trap=1 plus redirect 0x80 -> o_pc=0x100.
- Redirect to 0x42 -> o_pc=0x100, o_misaligned=1 for exactly one cycle, o_bad_addr=0x42.
- RUN at 0x30 with accept and i_halt -> o_pc=0x34, state=HALT, o_valid=0. Hold 5 cycles; redirect 0x200 -> RUN, o_pc=0x200.
- XLEN=32 at o_pc=0xFFFFFFFC accepted -> o_pc=0x0. Assert i_rst mid-stall -> o_pc=RESET_ADDR, state=BOOT, count=0.
